// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//
// Adds two W-bit operands (W = 4*NIBBLES) by pushing them one nibble per cycle,
// least-significant nibble first, through a single 4-bit carry-lookahead stage
// (adder_4bit_lookahead, defined at the bottom of this file). The carry between
// nibbles is kept in a register. The full-width sum is assembled in place and
// held behind an output valid/ready handshake.
//
// Optional feature macro: SERIAL_SUB_EN
//   defined   -> 'sub' port exists; sub=1 computes a-b (b inverted, carry-in 1)
//   undefined -> no 'sub' port, the block computes a+b+cin only
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   in_valid   in   a/b/cin (and sub) are valid
//   in_ready   out  block accepts operands (IDLE only)
//   a, b       in   W-bit operands
//   cin        in   carry into nibble 0
//   sub        in   subtract mode (SERIAL_SUB_EN only)
//   out_valid  out  sum/cout hold a completed result (DONE only)
//   out_ready  in   consumer takes the result
//   sum        out  W-bit result, meaningful only while out_valid=1
//   cout       out  carry out of bit W-1 (with sub=1: 1 means no borrow)

module nibble_serial_adder #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 cin,
`ifdef SERIAL_SUB_EN
    input  logic                 sub,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout
);

    localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e state_q, state_d;

    // Operands and result kept as nibble arrays so the active nibble is a plain index.
    logic [NIBBLES-1:0][3:0] a_q, a_d;
    logic [NIBBLES-1:0][3:0] b_q, b_d;
    logic [NIBBLES-1:0][3:0] sum_q, sum_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic                    carry_q, carry_d;
    logic                    cout_q, cout_d;

    logic [3:0] nib_a;
    logic [3:0] nib_b;
    logic [3:0] add_out;
    logic       add_carry;
    logic       carry_init;

`ifdef SERIAL_SUB_EN
    logic sub_q, sub_d;

    // Two's-complement subtract: a + ~b + 1, so cin is not used when sub=1.
    assign carry_init = sub ? 1'b1 : cin;
    assign nib_b      = b_q[idx_q] ^ {4{sub_q}};
`else
    assign carry_init = cin;
    assign nib_b      = b_q[idx_q];
`endif

    assign nib_a = a_q[idx_q];

    adder_4bit_lookahead u_add (
        .a     (nib_a),
        .b     (nib_b),
        .cin   (carry_q),
        .out   (add_out),
        .carry (add_carry)
    );

    // Next-state logic
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef SERIAL_SUB_EN
        sub_d   = sub_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = carry_init;
                    idx_d   = '0;
`ifdef SERIAL_SUB_EN
                    sub_d   = sub;
`endif
                    state_d = StRun;
                end
            end

            StRun: begin
                sum_d[idx_q] = add_out;
                carry_d      = add_carry;
                if (idx_q == LastIdx) begin
                    cout_d  = add_carry;
                    idx_d   = '0;
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            StDone: begin
                // Result and carry stay frozen until the consumer takes them.
                if (out_ready) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
`ifdef SERIAL_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
`ifdef SERIAL_SUB_EN
            sub_q   <= sub_d;
`endif
        end
    end

    // Outputs
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        sum       = sum_q;
        cout      = cout_q;
    end

endmodule

// adder_4bit_lookahead
//
// Purely combinational 4-bit carry-lookahead adder.
//   a, b   in   4-bit operands
//   cin    in   carry in
//   out    out  4-bit sum
//   carry  out  carry out of bit 3

module adder_4bit_lookahead (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] out,
    output logic       carry
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    always_comb begin
        g = a & b;
        p = a ^ b;

        // Every carry is a flat sum of products of generate/propagate terms.
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        carry = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

        out = p ^ c;
    end

endmodule
